scratchpad_crc_check: RTL and testbench

Upstream stage of the DS18B20 temperature path. Collects the 72-bit scratchpad read from a sensor, LSB first, as delivered by the 1-Wire bit layer. Runs the Dallas/Maxim CRC-8 serially over the frame. On a valid frame it presents the raw 16-bit two's-complement temperature and a convert_en strobe to the binary-to-BCD converter. On an invalid frame it raises an error flag and leaves the previous temperature untouched.

---
 rtl/ds18b20_pkg.sv | 15 +
 rtl/scratchpad_crc_check_if.sv | 25 ++
 rtl/crc8_dallas_serial.sv | 27 ++
 rtl/scratchpad_crc_check.sv | 137 +++++++++++++
 tb/tb_scratchpad_crc_check.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ds18b20_pkg.sv
// Shared constants and types for the DS18B20 scratchpad receive path.
package ds18b20_pkg;

    localparam int SCRATCHPAD_BITS = 72;
    localparam int TEMP_BITS       = 16;
    localparam int CNT_W           = 7;
    localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } state_t;

endpackage

// File: rtl/scratchpad_crc_check_if.sv
// Bit-layer input and converter-facing output bundle of the scratchpad checker.
interface scratchpad_crc_check_if #(
    parameter int IDX_W = 3
);
    logic             frame_start;
    logic [IDX_W-1:0] sensor_idx;
    logic             bit_valid;
    logic             bit_in;
    logic [15:0]      bin_temperature;
    logic [IDX_W-1:0] temp_idx;
    logic             convert_en;
    logic             crc_error;
    logic             frame_abort;
    logic             busy;

    modport master (
        output frame_start, sensor_idx, bit_valid, bit_in,
        input  bin_temperature, temp_idx, convert_en, crc_error, frame_abort, busy
    );

    modport slave (
        input  frame_start, sensor_idx, bit_valid, bit_in,
        output bin_temperature, temp_idx, convert_en, crc_error, frame_abort, busy
    );
endinterface

// File: rtl/crc8_dallas_serial.sv
// Serial Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected), one bit per enabled clock.
// Latency: crc reflects bit_in one clock after en; clear wins over en.
// Backpressure: none, caller gates en/clear with its own strobe.
module crc8_dallas_serial
    import ds18b20_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clear,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[0] ^ bit_in;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {1'b0, crc[7:1]} ^ (fb ? CRC8_POLY_REFL : 8'h00);
        end
    end

endmodule

// File: rtl/scratchpad_crc_check.sv
// Collects a 72-bit DS18B20 scratchpad, checks CRC-8 and publishes the raw temperature.
// Latency: convert_en/crc_error on the F1M tick after the tick accepting bit 71.
// Backpressure: none; bits are taken whenever bit_valid is high on an F1M tick.
module scratchpad_crc_check
    import ds18b20_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic F1M,
    scratchpad_crc_check_if.slave bus
);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   zero_flag;
    logic [TEMP_BITS-1:0]   temp_shift;
    logic [IDX_W-1:0]       idx_lat;
    logic [7:0]             crc;

    logic [TEMP_BITS-1:0]   bin_temperature_q;
    logic [IDX_W-1:0]       temp_idx_q;
    logic                   convert_en_q;
    logic                   crc_error_q;
    logic                   frame_abort_q;

    logic restart, accept, abort, check;
    logic frame_ok;

    // A stuck-low bus produces a zero CRC, so an all-zero frame must be rejected separately.
    assign frame_ok = (crc == 8'h00) && !zero_flag;

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        accept    = 1'b0;
        abort     = 1'b0;
        check     = 1'b0;
        if (F1M) begin
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        restart   = 1'b1;
                        state_nxt = RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (bus.frame_start) begin
                        restart   = 1'b1;
                        abort     = (bit_cnt != '0);
                        state_nxt = RECEIVE;
                    end else if (bus.bit_valid) begin
                        accept = 1'b1;
                        if (bit_cnt == CNT_W'(SCRATCHPAD_BITS - 1)) begin
                            state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    check = 1'b1;
                    if (bus.frame_start) begin
                        restart   = 1'b1;
                        state_nxt = RECEIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt           <= '0;
            zero_flag         <= 1'b1;
            temp_shift        <= '0;
            idx_lat           <= '0;
            bin_temperature_q <= '0;
            temp_idx_q        <= '0;
            convert_en_q      <= 1'b0;
            crc_error_q       <= 1'b0;
            frame_abort_q     <= 1'b0;
        end else if (F1M) begin
            convert_en_q  <= 1'b0;
            crc_error_q   <= 1'b0;
            frame_abort_q <= abort;
            if (check) begin
                if (frame_ok) begin
                    bin_temperature_q <= temp_shift;
                    temp_idx_q        <= idx_lat;
                    convert_en_q      <= 1'b1;
                end else begin
                    crc_error_q <= 1'b1;
                end
            end
            if (restart) begin
                bit_cnt    <= '0;
                zero_flag  <= 1'b1;
                temp_shift <= '0;
                idx_lat    <= bus.sensor_idx;
            end else if (accept) begin
                zero_flag <= zero_flag & ~bus.bit_in;
                if (bit_cnt < CNT_W'(TEMP_BITS)) begin
                    temp_shift[bit_cnt[3:0]] <= bus.bit_in;
                end
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    crc8_dallas_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .en     (accept),
        .clear  (restart),
        .bit_in (bus.bit_in),
        .crc    (crc)
    );

    assign bus.bin_temperature = bin_temperature_q;
    assign bus.temp_idx        = temp_idx_q;
    assign bus.convert_en      = convert_en_q;
    assign bus.crc_error       = crc_error_q;
    assign bus.frame_abort     = frame_abort_q;
    assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_scratchpad_crc_check.sv
// Bench for scratchpad_crc_check: fixed vectors, hand sequences and random frames vs a byte-level model.
module tb_scratchpad_crc_check;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic f1m = 1'b0;

    scratchpad_crc_check_if #(.IDX_W(3)) bus ();

    scratchpad_crc_check #(.IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .F1M (f1m),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [15:0] model_temp = 16'h0000;
    logic [2:0]  model_idx  = 3'd0;

    typedef struct {
        logic [71:0] frame;
        logic [2:0]  idx;
        int          pre_bits;
        logic        exp_abort;
        logic        exp_conv;
        logic        exp_err;
        logic [15:0] exp_temp;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[4];

    // Standard Dallas byte-oriented CRC over the first n bytes, LSB first.
    function automatic logic [7:0] dallas_crc(input logic [71:0] f, input int n);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            b = f[k*8 +: 8];
            for (int j = 0; j < 8; j++) begin
                if (((c ^ b) & 8'h01) != 0) c = (c >> 1) ^ 8'h8C;
                else                        c = c >> 1;
                b = b >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [71:0] with_crc(input logic [71:0] f);
        logic [71:0] r;
        r = f;
        r[71:64] = dallas_crc(f, 8);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic fs, input logic [2:0] idx, input logic bv, input logic b,
                        input int gap, input logic hold);
        @(negedge clk);
        bus.frame_start = fs;
        bus.sensor_idx  = idx;
        bus.bit_valid   = bv;
        bus.bit_in      = b;
        f1m             = 1'b1;
        @(negedge clk);
        f1m             = 1'b0;
        bus.frame_start = 1'b0;
        bus.bit_valid   = hold ? bv : 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (hold) bus.bit_in = 1'($urandom);
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [71:0] f, input int nbits, input int gap, input logic hold);
        for (int i = 0; i < nbits; i++) begin
            tick(1'b0, 3'($urandom), 1'b1, f[i], gap, hold);
        end
    endtask

    // Start tick (optionally with a competing bit that must be dropped), then 72 bits.
    task automatic send_frame(input logic [71:0] f, input logic [2:0] idx, input logic exp_abort,
                              input int gap, input logic hold);
        tick(1'b1, idx, 1'($urandom), 1'($urandom), gap, 1'b0);
        check("frame_abort_on_start", bus.frame_abort, exp_abort);
        check("busy_after_start", bus.busy, 1'b1);
        tick(1'b0, 3'($urandom), 1'b1, f[0], gap, hold);
        if (exp_abort) check("frame_abort_clears", bus.frame_abort, 1'b0);
        send_bits(f >> 1, 71, gap, hold);
        check("busy_in_check", bus.busy, 1'b1);
    endtask

    task automatic finish_frame(input logic ec, input logic ee, input logic [15:0] et,
                                input logic [2:0] ei, input int gap);
        tick(1'b0, 3'($urandom), 1'($urandom), 1'($urandom), gap, 1'b0);
        check("convert_en", bus.convert_en, ec);
        check("crc_error", bus.crc_error, ee);
        check("bin_temperature", bus.bin_temperature, et);
        check("temp_idx", bus.temp_idx, ei);
        tick(1'b0, 3'($urandom), 1'($urandom), 1'($urandom), gap, 1'b0);
        check("convert_en_pulse_end", bus.convert_en, 1'b0);
        check("crc_error_pulse_end", bus.crc_error, 1'b0);
        check("busy_idle", bus.busy, 1'b0);
    endtask

    task automatic model_frame(input logic [71:0] f, input logic [2:0] idx,
                               output logic ec, output logic ee);
        ec = (dallas_crc(f, 9) == 8'h00) && (f != 72'h0);
        ee = !ec;
        if (ec) begin
            model_temp = f[15:0];
            model_idx  = idx;
        end
    endtask

    initial begin
        logic [71:0] pwr, tmp, fr, fa, fb;
        logic ec, ee;
        logic [2:0] ix;

        bus.frame_start = 1'b0;
        bus.sensor_idx  = 3'd0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;

        pwr = 72'h1C_10_0C_FF_7F_46_4B_05_50;
        tmp = pwr;
        tmp[71:64] = 8'h1D;
        vecs[0] = '{pwr, 3'd2, 0, 1'b0, 1'b1, 1'b0, 16'h0550, 3'd2};
        vecs[1] = '{tmp, 3'd3, 0, 1'b0, 1'b0, 1'b1, 16'h0550, 3'd2};
        vecs[2] = '{72'h0, 3'd4, 0, 1'b0, 1'b0, 1'b1, 16'h0550, 3'd2};
        vecs[3] = '{with_crc(72'h00_10_0F_FF_7F_46_4B_01_91), 3'd6, 30, 1'b1, 1'b1, 1'b0,
                    16'h0191, 3'd6};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_bin_temperature", bus.bin_temperature, 16'h0000);
        check("rst_temp_idx", bus.temp_idx, 3'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_pulses", {bus.convert_en, bus.crc_error, bus.frame_abort}, 3'b000);

        // Bits arriving in IDLE must not start a frame.
        for (int i = 0; i < 4; i++) tick(1'b0, 3'd1, 1'b1, 1'b1, 0, 1'b0);
        check("idle_ignores_bits", bus.busy, 1'b0);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].pre_bits > 0) begin
                tick(1'b1, 3'd7, 1'b0, 1'b0, 0, 1'b0);
                send_bits(72'hA5A5_A5A5_A5A5_A5A5_A5, vecs[v].pre_bits, 0, 1'b0);
            end
            send_frame(vecs[v].frame, vecs[v].idx, vecs[v].exp_abort, 0, 1'b0);
            finish_frame(vecs[v].exp_conv, vecs[v].exp_err, vecs[v].exp_temp, vecs[v].exp_idx, 0);
        end
        model_temp = 16'h0191;
        model_idx  = 3'd6;

        // frame_start on the CHECK tick: result still produced, next frame starts at once.
        fa = with_crc(72'h00_10_0F_FF_7F_46_4B_FF_F8);
        fb = with_crc(72'h00_10_0F_FF_7F_46_4B_00_32);
        tick(1'b1, 3'd1, 1'b0, 1'b0, 0, 1'b0);
        send_bits(fa, 72, 0, 1'b0);
        tick(1'b1, 3'd5, 1'b0, 1'b0, 0, 1'b0);
        check("chain_convert_en", bus.convert_en, 1'b1);
        check("chain_temp_a", bus.bin_temperature, 16'hFFF8);
        check("chain_idx_a", bus.temp_idx, 3'd1);
        check("chain_busy", bus.busy, 1'b1);
        check("chain_no_abort", bus.frame_abort, 1'b0);
        send_bits(fb, 72, 0, 1'b0);
        finish_frame(1'b1, 1'b0, 16'h0032, 3'd5, 0);
        model_temp = 16'h0032;
        model_idx  = 3'd5;

        for (int r = 0; r < 16; r++) begin
            fr = {8'h00, 32'($urandom), 32'($urandom)};
            fr = with_crc(fr);
            if ($urandom_range(0, 1) == 1) fr[71:64] = fr[71:64] ^ (8'h01 << $urandom_range(0, 7));
            ix = 3'($urandom);
            model_frame(fr, ix, ec, ee);
            send_frame(fr, ix, 1'b0, $urandom_range(0, 2), 1'b0);
            finish_frame(ec, ee, model_temp, model_idx, 0);
        end

        // bit_valid held high with sparse F1M; only F1M ticks take bits.
        fr = with_crc(72'h00_10_0F_FF_7F_46_4B_01_A2);
        model_frame(fr, 3'd3, ec, ee);
        send_frame(fr, 3'd3, 1'b0, 49, 1'b1);
        finish_frame(ec, ee, model_temp, model_idx, 49);
        check("held_valid_frame_ok", ec, 1'b1);

        // Reset in the middle of a frame.
        tick(1'b1, 3'd4, 1'b0, 1'b0, 0, 1'b0);
        send_bits(pwr, 40, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_bin_temperature", bus.bin_temperature, 16'h0000);
        check("midrst_temp_idx", bus.temp_idx, 3'd0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_pulses", {bus.convert_en, bus.crc_error, bus.frame_abort}, 3'b000);
        model_temp = 16'h0000;
        model_idx  = 3'd0;
        model_frame(pwr, 3'd7, ec, ee);
        send_frame(pwr, 3'd7, 1'b0, 0, 1'b0);
        finish_frame(ec, ee, model_temp, model_idx, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
